bch_syndrome: RTL
=================

Name: bch_syndrome

Overview:
- Serial syndrome generator for the multi-code BCH decoder; sits directly upstream of the GF-multiplier-based key-equation / error-locator stage.
- Consumes the received word one bit per cycle (highest-order coefficient first) and produces the packed syndromes S1..S2t via Horner's rule.
- Supports three codes:
  - i_code=0: m=6, n=63, t=2, p(x)=x^6+x+1.
  - i_code=1: m=8, n=255, t=2, p(x)=x^8+x^4+x^3+x^2+1.
  - i_code=2: m=10, n=1023, t=4, p(x)=x^10+x^3+1.
- Flags an error-free word so downstream stages can be skipped.

Parameters:
- MAXM, 10, widest field width; every syndrome lane is MAXM bits.
- NSYN, 8, number of syndrome lanes (2*t_max).
- CW, 10, bit-counter width (covers n-1=1022).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_start  in  1  one-cycle pulse that begins a new word; sampled only in IDLE.
- i_code  in  2  code select; latched on accepted i_start; 2'b11 is illegal.
- i_valid  in  1  i_bit is valid this cycle.
- i_bit  in  1  received coefficient r_i, first bit = r_{n-1}.
- o_ready  out  1  block accepts i_bit this cycle.
- o_syn_valid  out  1  o_syndrome/o_err_free are valid.
- i_syn_ready  in  1  downstream accepts syndromes.
- o_syndrome  out  NSYN*MAXM  S_k in bits [10k-1:10k-10], k=1..8.
- o_err_free  out  1  all active syndromes are zero.
- o_code  out  2  latched code, held alongside o_syndrome.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State goes to IDLE; counter and all syndrome registers clear to 0.
  - o_ready=0, o_syn_valid=0, o_syndrome=0, o_err_free=0, o_code=0.
  - Reset in any state aborts the word in progress; no partial result is ever presented.
- States:
  - IDLE:
    - o_ready=0.
    - i_start=1 with i_code<=2: latch code, clear S1..S8 and the counter, go to ACCUM.
    - i_start with i_code=3: ignored, stay IDLE.
  - ACCUM:
    - o_ready=1.
    - On each accepted bit (i_valid&o_ready), every active S_j <= S_j·α^j XOR i_bit (j=1..2t), using the latched p(x). Reduction keeps bits above m-1 at zero.
    - Counter increments per accepted bit.
    - Cycles with i_valid=0 change nothing (gaps allowed).
    - The accepted bit with counter == n-1 is the last one; go to DONE next cycle.
    - i_start is ignored in ACCUM.
  - DONE:
    - o_ready=0, o_syn_valid=1.
    - o_syndrome, o_err_free and o_code are stable while waiting.
    - o_syn_valid&i_syn_ready: go to IDLE next cycle; o_syn_valid drops.
- Latency:
  - o_syn_valid rises the cycle after the n-th bit is accepted.
  - Minimum word time is 1 (start) + n + 1 cycles.
- Inactive lanes:
  - For t=2 codes, S5..S8 are held at 0.
  - Bits [9:m] of every lane are 0.
- o_err_free:
  - Combinational OR-reduce over the active lanes, inverted.
  - Only meaningful while o_syn_valid=1; it is 0 elsewhere.
- Multiply by α^j: constant per lane and per code. Implement as j chained xtime steps (shift left, XOR p(x) low terms on carry out of bit m-1), muxed by the latched code. No general GF multiplier is used.
- Simultaneous events:
  - i_start in DONE is ignored.
  - i_syn_ready outside DONE is ignored.
  - The block is half-duplex: the next i_start is accepted no earlier than the first IDLE cycle after handshake.

Decomposition:
- Shared package bch_pkg:
  - Code-select encodings CODE_M6/M8/M10.
  - Per-code m, n-1, t and p(x) low-term masks (0x03, 0x1D, 0x009).
  - MAXM and NSYN.
  - State encoding IDLE/ACCUM/DONE.
- One sub-module: gf_mul_alpha_pow.
  - Parameter J (1..8); inputs value[9:0] and code[1:0]; output value·α^J reduced.
  - Instantiated once per lane.

Test Plan:
- All-zero word, code 0 (63 zeros, back-to-back valid) -> o_syn_valid on the cycle after bit 63; all S=0; o_err_free=1; o_code=0.
- Code 0, single 1 at r_0 (last bit) -> S1..S4=0x001; S5..S8=0; o_err_free=0.
- Code 0, single 1 at r_1 -> S1=0x02, S2=0x04, S3=0x08, S4=0x10. Same word with the 1 at r_6 -> S1=0x03 (α^6=α+1).
- Code 2, single 1 at r_1 with random i_valid gaps -> S1..S8 = 0x002, 0x004, …, 0x100, then S8=α^8=0x100 and lanes consistent with p(x)=x^10+x^3+1. Check S_k=0x008·… per golden model; result identical to the gap-free run.
- Backpressure: hold i_syn_ready=0 for 20 cycles in DONE -> outputs stable, o_ready=0, i_start ignored; release -> IDLE next cycle.
- Reset: pull i_rst_n low mid-ACCUM (code 1, bit 100) -> next cycle all outputs 0, state IDLE. A fresh code-1 all-zero word afterwards gives o_err_free=1.

Source files
------------

// File: rtl/bch_pkg.sv
// Shared definitions for the multi-code BCH syndrome generator: code selects, per-code field
// parameters and the single-step multiply-by-alpha used by every syndrome lane.
package bch_pkg;

    localparam int unsigned MAXM = 10;
    localparam int unsigned NSYN = 8;

    typedef enum logic [1:0] {
        CodeM6  = 2'd0,
        CodeM8  = 2'd1,
        CodeM10 = 2'd2
    } code_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic logic [3:0] code_m(logic [1:0] code);
        case (code)
            CodeM8:  return 4'd8;
            CodeM10: return 4'd10;
            default: return 4'd6;
        endcase
    endfunction

    function automatic logic [9:0] code_nm1(logic [1:0] code);
        case (code)
            CodeM8:  return 10'd254;
            CodeM10: return 10'd1022;
            default: return 10'd62;
        endcase
    endfunction

    function automatic logic [2:0] code_t(logic [1:0] code);
        case (code)
            CodeM10: return 3'd4;
            default: return 3'd2;
        endcase
    endfunction

    // Low-order terms of p(x); the x^m term is implied by the carry out of bit m-1.
    function automatic logic [9:0] code_poly(logic [1:0] code);
        case (code)
            CodeM8:  return 10'h01D;
            CodeM10: return 10'h009;
            default: return 10'h003;
        endcase
    endfunction

    function automatic logic [9:0] xtime(logic [9:0] v, logic [1:0] code);
        logic [9:0] r;
        r = {v[8:0], 1'b0} & ~(10'h3FF << code_m(code));
        if (v[code_m(code) - 4'd1]) r = r ^ code_poly(code);
        return r;
    endfunction

endpackage

// File: rtl/bch_syndrome_if.sv
// Handshake and result bundle between the bit source, the syndrome generator and the
// downstream key-equation stage.
interface bch_syndrome_if #(
    parameter int unsigned MAXM = 10,
    parameter int unsigned NSYN = 8
);
    logic                 i_start;
    logic [1:0]           i_code;
    logic                 i_valid;
    logic                 i_bit;
    logic                 o_ready;
    logic                 o_syn_valid;
    logic                 i_syn_ready;
    logic [NSYN*MAXM-1:0] o_syndrome;
    logic                 o_err_free;
    logic [1:0]           o_code;

    modport slave (
        input  i_start, i_code, i_valid, i_bit, i_syn_ready,
        output o_ready, o_syn_valid, o_syndrome, o_err_free, o_code
    );

    modport master (
        output i_start, i_code, i_valid, i_bit, i_syn_ready,
        input  o_ready, o_syn_valid, o_syndrome, o_err_free, o_code
    );
endinterface

// File: rtl/gf_mul_alpha_pow.sv
// Constant multiply by alpha^J in the field selected by code_i, built from J chained
// multiply-by-alpha steps.
module gf_mul_alpha_pow #(
    parameter int unsigned J = 1
) (
    input  logic [9:0] value_i,
    input  logic [1:0] code_i,
    output logic [9:0] value_o
);
    import bch_pkg::*;

    always_comb begin
        value_o = value_i;
        for (int unsigned k = 0; k < J; k++) value_o = xtime(value_o, code_i);
    end
endmodule

// File: rtl/bch_syndrome.sv
// Serial BCH syndrome generator: Horner evaluation of r(alpha^j), j = 1..2t, one received
// bit per cycle, highest-order coefficient first.
module bch_syndrome #(
    parameter int unsigned MAXM = bch_pkg::MAXM,
    parameter int unsigned NSYN = bch_pkg::NSYN,
    parameter int unsigned CW   = 10
) (
    input logic           i_clk,
    input logic           i_rst_n,
    bch_syndrome_if.slave syn_if
);
    import bch_pkg::*;

    state_e          state_q;
    logic [1:0]      code_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;
    logic            syn_valid_q;
    logic [MAXM-1:0] syn_q   [NSYN];
    logic [MAXM-1:0] syn_mul [NSYN];
    logic [NSYN-1:0] lane_active;
    logic            any_nz;
    logic            last_bit;

    for (genvar g = 0; g < NSYN; g++) begin : g_lane
        gf_mul_alpha_pow #(
            .J(g + 1)
        ) u_mul (
            .value_i(syn_q[g]),
            .code_i (code_q),
            .value_o(syn_mul[g])
        );

        assign lane_active[g] = (4'(g) < {code_t(code_q), 1'b0});
        // Results are only exposed once the whole word has been absorbed.
        assign syn_if.o_syndrome[g*MAXM +: MAXM] = syn_valid_q ? syn_q[g] : '0;
    end

    always_comb begin
        any_nz = 1'b0;
        for (int unsigned i = 0; i < NSYN; i++) begin
            any_nz = any_nz | (lane_active[i] & (|syn_q[i]));
        end
    end

    assign last_bit           = (cnt_q == code_nm1(code_q));
    assign syn_if.o_ready     = ready_q;
    assign syn_if.o_syn_valid = syn_valid_q;
    assign syn_if.o_err_free  = syn_valid_q & ~any_nz;
    assign syn_if.o_code      = code_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            code_q      <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            syn_valid_q <= 1'b0;
            for (int unsigned i = 0; i < NSYN; i++) syn_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (syn_if.i_start && (syn_if.i_code != 2'b11)) begin
                        code_q  <= syn_if.i_code;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= StAccum;
                        for (int unsigned i = 0; i < NSYN; i++) syn_q[i] <= '0;
                    end
                end
                StAccum: begin
                    if (syn_if.i_valid) begin
                        for (int unsigned i = 0; i < NSYN; i++) begin
                            if (lane_active[i]) begin
                                syn_q[i] <= syn_mul[i] ^ {{(MAXM-1){1'b0}}, syn_if.i_bit};
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (last_bit) begin
                            ready_q     <= 1'b0;
                            syn_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (syn_if.i_syn_ready) begin
                        syn_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
